// File: rtl/configuration_registers_tx.sv
// Serializes one register transfer (address then data, least significant packet
// first) onto a byte stream. Optional trailing XOR checksum: CONFIG_REGISTERS_TX_CHECKSUM_EN.
module configuration_registers_tx #(
  parameter int TX_DATA_WIDTH    = 8,
  parameter int REG_ADDR_WIDTH   = 64,
  parameter int REG_DATA_WIDTH   = 32,
  parameter int REG_ADDR_PACKETS = 8,
  parameter int REG_DATA_PACKETS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic                      register_rdy,
  output logic                      register_ack,
  output logic [TX_DATA_WIDTH-1:0]  tx_data,
  output logic                      tx_rdy,
  input  logic                      tx_ack,
  output logic [1:0]                state_dbg
);

  // Handshake: on both interfaces a transfer happens on a rising clk edge where
  // rdy=1 and ack=1; the rdy side holds its payload stable until then.

  localparam int MAX_PACKETS = (REG_ADDR_PACKETS > REG_DATA_PACKETS) ? REG_ADDR_PACKETS
                                                                     : REG_DATA_PACKETS;
  localparam int CNT_W      = (MAX_PACKETS > 1) ? $clog2(MAX_PACKETS) : 1;
  localparam int ADDR_IDX_W = (REG_ADDR_PACKETS > 1) ? $clog2(REG_ADDR_PACKETS) : 1;
  localparam int DATA_IDX_W = (REG_DATA_PACKETS > 1) ? $clog2(REG_DATA_PACKETS) : 1;
`ifdef CONFIG_REGISTERS_TX_CHECKSUM_EN
  localparam int NUM_STATES = 4;
`else
  localparam int NUM_STATES = 3;
`endif
  localparam int STATE_W = $clog2(NUM_STATES);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_SEND_ADDR,
    ST_SEND_DATA
`ifdef CONFIG_REGISTERS_TX_CHECKSUM_EN
    , ST_SEND_CHK
`endif
  } state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic capture;
  logic [REG_ADDR_PACKETS-1:0][TX_DATA_WIDTH-1:0] addr_q;
  logic [REG_DATA_PACKETS-1:0][TX_DATA_WIDTH-1:0] data_q;
  logic [ADDR_IDX_W-1:0] addr_idx;
  logic [DATA_IDX_W-1:0] data_idx;

  assign addr_idx  = count[ADDR_IDX_W-1:0];
  assign data_idx  = count[DATA_IDX_W-1:0];
  assign state_dbg = 2'(state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      count        <= '0;
      register_ack <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      register_ack <= capture;
    end
  end

  // Frame holding registers; contents are meaningless until the first capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q <= register_addr;
      data_q <= register_data;
    end
  end

`ifdef CONFIG_REGISTERS_TX_CHECKSUM_EN
  logic [TX_DATA_WIDTH-1:0] checksum;

  always_comb begin
    checksum = '0;
    for (int i = 0; i < REG_ADDR_PACKETS; i++) checksum = checksum ^ addr_q[i];
    for (int i = 0; i < REG_DATA_PACKETS; i++) checksum = checksum ^ data_q[i];
  end
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    tx_rdy     = 1'b0;
    tx_data    = '0;
    case (state)
      ST_IDLE: begin
        if (register_rdy && !rst) begin
          capture    = 1'b1;
          count_next = '0;
          state_next = ST_SEND_ADDR;
        end
      end
      ST_SEND_ADDR: begin
        tx_rdy  = 1'b1;
        tx_data = addr_q[addr_idx];
        if (tx_ack) begin
          if (count == CNT_W'(REG_ADDR_PACKETS - 1)) begin
            count_next = '0;
            state_next = ST_SEND_DATA;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      ST_SEND_DATA: begin
        tx_rdy  = 1'b1;
        tx_data = data_q[data_idx];
        if (tx_ack) begin
          if (count == CNT_W'(REG_DATA_PACKETS - 1)) begin
            count_next = '0;
`ifdef CONFIG_REGISTERS_TX_CHECKSUM_EN
            state_next = ST_SEND_CHK;
`else
            state_next = ST_IDLE;
`endif
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
`ifdef CONFIG_REGISTERS_TX_CHECKSUM_EN
      ST_SEND_CHK: begin
        tx_rdy  = 1'b1;
        tx_data = checksum;
        if (tx_ack) state_next = ST_IDLE;
      end
`endif
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_configuration_registers_tx.sv
// Directed bench for configuration_registers_tx: table-driven frames plus
// backpressure, back-to-back, input-isolation and mid-frame reset sequences.
module tb_configuration_registers_tx;

  localparam int TW = 8;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int AP = 8;
  localparam int DP = 4;
`ifdef CONFIG_REGISTERS_TX_CHECKSUM_EN
  localparam int FRAME_LEN = AP + DP + 1;
`else
  localparam int FRAME_LEN = AP + DP;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] register_data;
  logic [AW-1:0] register_addr;
  logic          register_rdy;
  logic          register_ack;
  logic [TW-1:0] tx_data;
  logic          tx_rdy;
  logic          tx_ack;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  configuration_registers_tx dut (
    .clk           (clk),
    .rst           (rst),
    .register_data (register_data),
    .register_addr (register_addr),
    .register_rdy  (register_rdy),
    .register_ack  (register_ack),
    .tx_data       (tx_data),
    .tx_rdy        (tx_rdy),
    .tx_ack        (tx_ack),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       tack;
    logic       exp_ack;
    logic       exp_trdy;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  logic [AW-1:0] basic_addr = 64'h0807060504030201;
  logic [DW-1:0] basic_data = 32'hDDCCBBAA;
  logic [7:0] basic_bytes [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                   8'h08, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h08};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference packet model: address packets, data packets, optional XOR.
  function automatic logic [7:0] frame_byte(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                            input int i);
    logic [7:0] x;
    if (i < AP) return a[i*8 +: 8];
    if (i < AP + DP) return d[(i-AP)*8 +: 8];
    x = '0;
    for (int k = 0; k < AP; k++) x = x ^ a[k*8 +: 8];
    for (int k = 0; k < DP; k++) x = x ^ d[k*8 +: 8];
    return x;
  endfunction

  // driver tasks
  task automatic build_basic_vecs();
    vec_t v;
    vecs.delete();
    v.rdy = 1'b1; v.tack = 1'b1; v.exp_ack = 1'b0; v.exp_trdy = 1'b0; v.exp_data = 8'h00;
    vecs.push_back(v);
    for (int i = 0; i < FRAME_LEN; i++) begin
      v.rdy = (i == 0); v.tack = 1'b1; v.exp_ack = (i == 0); v.exp_trdy = 1'b1;
      v.exp_data = basic_bytes[i];
      vecs.push_back(v);
    end
    v.rdy = 1'b0; v.tack = 1'b1; v.exp_ack = 1'b0; v.exp_trdy = 1'b0; v.exp_data = 8'h00;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      register_rdy = vecs[i].rdy;
      tx_ack       = vecs[i].tack;
      #1;
      check($sformatf("%s[%0d].register_ack", tag, i), register_ack, vecs[i].exp_ack);
      check($sformatf("%s[%0d].tx_rdy", tag, i), tx_rdy, vecs[i].exp_trdy);
      check($sformatf("%s[%0d].tx_data", tag, i), tx_data, vecs[i].exp_data);
      step();
    end
    register_rdy = 1'b0;
    tx_ack       = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    bit         acked = 0;
    int         cyc = 0;
    register_addr = basic_addr;
    register_data = basic_data;
    for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(basic_bytes[i]);
    register_rdy = 1'b1;
    while (exp_q.size() > 0 && cyc < 200) begin
      tx_ack = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      if (prev_stall) check("bp_stable", tx_data, prev_data);
      if (tx_rdy && tx_ack) check("bp_byte", tx_data, exp_q.pop_front());
      prev_stall = tx_rdy && !tx_ack;
      prev_data  = tx_data;
      if (register_ack) acked = 1;
      step();
      if (acked) register_rdy = 1'b0;
      cyc++;
    end
    check("bp_bytes_left", exp_q.size(), 0);
    tx_ack = 1'b0;
    #1;
    check("bp_end_tx_rdy", tx_rdy, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [AW-1:0] a2 = 64'h1;
    logic [DW-1:0] d2 = 32'h2;
    int ack_count = 0;
    exp_q.push_back(9'h000);
    for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back({1'b1, frame_byte(basic_addr, basic_data, i)});
    exp_q.push_back(9'h000);
    for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back({1'b1, frame_byte(a2, d2, i)});
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h000);
    register_addr = basic_addr;
    register_data = basic_data;
    register_rdy  = 1'b1;
    tx_ack        = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      check("b2b_stream", {tx_rdy, tx_data}, e);
      if (register_ack) ack_count++;
      step();
      if (ack_count == 1) begin
        register_addr = a2;
        register_data = d2;
      end
      if (ack_count == 2) register_rdy = 1'b0;
    end
    check("b2b_ack_count", ack_count, 2);
    tx_ack = 1'b0;
  endtask

  task automatic test_isolation();
    logic [AW-1:0] a = 64'h1122334455667788;
    logic [DW-1:0] d = 32'h99AABBCC;
    register_addr = a;
    register_data = d;
    tx_ack = 1'b1;
    for (int cyc = 0; cyc < FRAME_LEN + 3; cyc++) begin
      register_rdy = (cyc <= 1) || (cyc == AP + 2);
      if (cyc >= 2) begin
        register_addr = 64'hFFEEDDCCBBAA0099 ^ AW'(cyc);
        register_data = 32'h5A5A5A5A ^ DW'(cyc);
      end
      #1;
      if (cyc == AP + 2) check("iso_state_send_data", state_dbg, 2'd2);
      check($sformatf("iso[%0d].register_ack", cyc), register_ack, (cyc == 1));
      check($sformatf("iso[%0d].tx_rdy", cyc), tx_rdy, (cyc >= 1 && cyc <= FRAME_LEN));
      if (cyc >= 1 && cyc <= FRAME_LEN)
        check($sformatf("iso[%0d].tx_data", cyc), tx_data, frame_byte(a, d, cyc - 1));
      step();
    end
    register_rdy = 1'b0;
    tx_ack = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    register_addr = basic_addr;
    register_data = basic_data;
    register_rdy  = 1'b1;
    tx_ack        = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      if (cyc >= 1) check($sformatf("rmf_byte%0d", cyc), tx_data, basic_bytes[cyc-1]);
      step();
      if (cyc == 1) register_rdy = 1'b0;
    end
    // five bytes accepted; reset while a transfer and a new request are offered
    register_rdy = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    register_rdy = 1'b0;
    tx_ack = 1'b0;
    #1;
    check("rmf_tx_rdy", tx_rdy, 1'b0);
    check("rmf_register_ack", register_ack, 1'b0);
    check("rmf_state", state_dbg, 2'd0);
    check("rmf_tx_data", tx_data, 8'h00);
    step();
    build_basic_vecs();
    run_vecs("rmf_restart");
  endtask

  initial begin
    rst = 1'b1;
    register_rdy = 1'b1;
    tx_ack = 1'b1;
    register_addr = '0;
    register_data = '0;
    step();
    step();
    register_rdy = 1'b0;
    tx_ack = 1'b0;
    #1;
    check("reset_register_ack", register_ack, 1'b0);
    check("reset_tx_rdy", tx_rdy, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_state", state_dbg, 2'd0);
    rst = 1'b0;
    step();

    register_addr = basic_addr;
    register_data = basic_data;
    build_basic_vecs();
    run_vecs("basic");

    test_backpressure();
    test_back_to_back();
    step();
    test_isolation();
    test_reset_mid_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
